// File: rtl/spr_access_ctrl_pkg.sv
// rtl/spr_access_ctrl_pkg.sv - SPRN constants, sequencer state encoding and SPRN legality helper
package spr_access_ctrl_pkg;

    localparam int unsigned SPRN_XER  = 1;
    localparam int unsigned SPRN_LR   = 8;
    localparam int unsigned SPRN_CTR  = 9;
    localparam int unsigned SPRN_SRR0 = 26;
    localparam int unsigned SPRN_SRR1 = 27;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXC_S1 = 2'd1,
        ST_CTR_WB = 2'd2
    } spr_state_e;

    function automatic logic sprn_known(input int unsigned sprn);
        return (sprn == SPRN_XER) || (sprn == SPRN_LR) || (sprn == SPRN_CTR) ||
               (sprn == SPRN_SRR0) || (sprn == SPRN_SRR1);
    endfunction

endpackage

// File: rtl/spr_access_ctrl_if.sv
// rtl/spr_access_ctrl_if.sv - requester and SPR-file signals of spr_access_ctrl (SPR_ILLEGAL_CHK_EN adds spr_illegal)
interface spr_access_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          exc_req;
    logic [DW-1:0] exc_pc;
    logic [DW-1:0] exc_msr;
    logic          exc_done;
    logic          br_ctr_dec;
    logic          br_done;
    logic          br_ctr_zero;
    logic          br_lr_wr;
    logic [DW-1:0] br_lr_val;
    logic          mt_req;
    logic [AW-1:0] mt_sprn;
    logic [DW-1:0] mt_data;
    logic          mt_gnt;
    logic          mf_req;
    logic [AW-1:0] mf_sprn;
    logic          mf_gnt;
    logic [DW-1:0] mf_data;
    logic          spr_wr;
    logic [AW-1:0] spr_waddr;
    logic [DW-1:0] spr_wd;
    logic          lr_wr;
    logic [DW-1:0] lr_wd;
    logic [AW-1:0] spr_raddr;
    logic [DW-1:0] spr_rd;
`ifdef SPR_ILLEGAL_CHK_EN
    logic          spr_illegal;
`endif

    modport master (
        output exc_req, exc_pc, exc_msr, br_ctr_dec, br_lr_wr, br_lr_val,
               mt_req, mt_sprn, mt_data, mf_req, mf_sprn, spr_rd,
        input  exc_done, br_done, br_ctr_zero, mt_gnt, mf_gnt, mf_data,
               spr_wr, spr_waddr, spr_wd, lr_wr, lr_wd, spr_raddr
`ifdef SPR_ILLEGAL_CHK_EN
        , input spr_illegal
`endif
    );

    modport slave (
        input  exc_req, exc_pc, exc_msr, br_ctr_dec, br_lr_wr, br_lr_val,
               mt_req, mt_sprn, mt_data, mf_req, mf_sprn, spr_rd,
        output exc_done, br_done, br_ctr_zero, mt_gnt, mf_gnt, mf_data,
               spr_wr, spr_waddr, spr_wd, lr_wr, lr_wd, spr_raddr
`ifdef SPR_ILLEGAL_CHK_EN
        , output spr_illegal
`endif
    );

endinterface

// File: rtl/spr_access_ctrl_rr_arb2.sv
// rtl/spr_access_ctrl_rr_arb2.sv - two-way round-robin arbiter, the requester not granted last wins
module spr_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    logic rr_last;  // 1: a was granted last, 0: b was (or nothing yet)

    assign gnt_a = req_a && (!req_b || !rr_last);
    assign gnt_b = req_b && !gnt_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b0;
        end else if (gnt_a) begin
            rr_last <= 1'b1;
        end else if (gnt_b) begin
            rr_last <= 1'b0;
        end
    end

endmodule

// File: rtl/spr_access_ctrl.sv
// rtl/spr_access_ctrl.sv - SPR port sequencer/arbiter; SPR_ILLEGAL_CHK_EN adds the spr_illegal output
module spr_access_ctrl
    import spr_access_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    spr_access_ctrl_if.slave bus
);
    localparam logic [AW-1:0] A_LR   = AW'(SPRN_LR);
    localparam logic [AW-1:0] A_CTR  = AW'(SPRN_CTR);
    localparam logic [AW-1:0] A_SRR0 = AW'(SPRN_SRR0);
    localparam logic [AW-1:0] A_SRR1 = AW'(SPRN_SRR1);

    spr_state_e    state, state_nxt;
    logic [DW-1:0] ctr_q;
    logic          arb_en, mt_req_v, mf_req_v, mt_gnt, mf_gnt, mt_bad, mf_bad;

    // An LR update on the dedicated port owns LR this cycle; pipeline LR accesses wait.
    assign arb_en   = (state == ST_IDLE) && !bus.exc_req && !bus.br_ctr_dec;
    assign mt_req_v = arb_en && bus.mt_req && !(bus.br_lr_wr && (bus.mt_sprn == A_LR));
    assign mf_req_v = arb_en && bus.mf_req && !(bus.br_lr_wr && (bus.mf_sprn == A_LR));

    spr_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (mt_req_v),
        .req_b (mf_req_v),
        .gnt_a (mt_gnt),
        .gnt_b (mf_gnt)
    );

`ifdef SPR_ILLEGAL_CHK_EN
    assign mt_bad          = !sprn_known(32'(bus.mt_sprn));
    assign mf_bad          = !sprn_known(32'(bus.mf_sprn));
    assign bus.spr_illegal = (mt_gnt && mt_bad) || (mf_gnt && mf_bad);
`else
    assign mt_bad = 1'b0;
    assign mf_bad = 1'b0;
`endif

    assign bus.mt_gnt = mt_gnt;
    assign bus.mf_gnt = mf_gnt;
    assign bus.lr_wr  = bus.br_lr_wr;
    assign bus.lr_wd  = bus.br_lr_wr ? bus.br_lr_val : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
        end else if ((state == ST_IDLE) && !bus.exc_req && bus.br_ctr_dec) begin
            ctr_q <= bus.spr_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.exc_req) begin
                    state_nxt = ST_EXC_S1;
                end else if (bus.br_ctr_dec) begin
                    state_nxt = ST_CTR_WB;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.exc_done    = 1'b0;
        bus.br_done     = 1'b0;
        bus.br_ctr_zero = 1'b0;
        bus.mf_data     = '0;
        bus.spr_wr      = 1'b0;
        bus.spr_waddr   = '0;
        bus.spr_wd      = '0;
        bus.spr_raddr   = '0;
        case (state)
            ST_IDLE: begin
                if (bus.exc_req) begin
                    bus.spr_wr    = 1'b1;
                    bus.spr_waddr = A_SRR0;
                    bus.spr_wd    = bus.exc_pc;
                end else if (bus.br_ctr_dec) begin
                    bus.spr_raddr = A_CTR;
                end else if (mt_gnt) begin
                    if (!mt_bad) begin
                        bus.spr_wr    = 1'b1;
                        bus.spr_waddr = bus.mt_sprn;
                        bus.spr_wd    = bus.mt_data;
                    end
                end else if (mf_gnt) begin
                    bus.spr_raddr = bus.mf_sprn;
                    if (!mf_bad) begin
                        bus.mf_data = bus.spr_rd;
                    end
                end
            end
            ST_EXC_S1: begin
                bus.spr_wr    = 1'b1;
                bus.spr_waddr = A_SRR1;
                bus.spr_wd    = bus.exc_msr;
                bus.exc_done  = 1'b1;
            end
            ST_CTR_WB: begin
                bus.spr_wr      = 1'b1;
                bus.spr_waddr   = A_CTR;
                bus.spr_wd      = ctr_q - DW'(1);
                bus.br_done     = 1'b1;
                bus.br_ctr_zero = (ctr_q == DW'(1));
            end
            default: ;
        endcase
    end

endmodule
